// File: rtl/uart_pkg.sv
// Shared UART frame-format definitions, used by the transmitter and the
// parametrised receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // 230400 baud from a 50 MHz system clock
  localparam int DEFAULT_CLKS_PER_BIT = 217;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side port bundle of uart_tx_fifo, plus the line outputs and a
// debug view of the transmit FSM state.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) ();
  import uart_pkg::*;

  // Valid/ready: a word moves on a rising edge where i_tx_valid && o_tx_ready.
  // o_tx_ready depends only on FIFO state, never on i_tx_valid; a producer
  // that raises i_tx_valid keeps i_tx_data stable until the transfer happens.
  logic                          i_tx_valid;
  logic [DATA_BITS-1:0]          i_tx_data;
  logic                          o_tx_ready;
  logic                          o_tx_serial;
  logic                          o_tx_active;
  logic                          o_tx_done;
  logic [$clog2(FIFO_DEPTH):0]   o_fifo_count;
  tx_state_t                     tx_state;

  modport master (
    output i_tx_valid, i_tx_data,
    input  o_tx_ready, o_tx_serial, o_tx_active, o_tx_done, o_fifo_count, tx_state
  );

  modport slave (
    input  i_tx_valid, i_tx_data,
    output o_tx_ready, o_tx_serial, o_tx_active, o_tx_done, o_fifo_count, tx_state
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; full/empty come from pointer
// comparison and the word at the head is visible on rdata.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words queue in a FIFO and are sent as
// back-to-back frames with configurable data bits, parity and stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic          i_clk_sys,
  input  logic          i_rst,
  uart_tx_fifo_if.slave tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
  end

  tx_state_t            state_q, state_d;
  logic [CW-1:0]        baud_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 serial_q, active_q, done_q;
  logic                 pop, done_d, line_d, baud_last;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic [AW:0]          fifo_count;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_clk_sys),
    .rst   (i_rst),
    .push  (tx.i_tx_valid),
    .pop   (pop),
    .wdata (tx.i_tx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_last = (baud_cnt_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // The final stop cycle pops the next word itself, so frames abut.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    line_d  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        line_d = 1'b0;
        if (baud_last) state_d = ST_DATA;
      end
      ST_DATA: begin
        line_d = shift_q[0];
        if (baud_last && bit_cnt_q == BW'(DATA_BITS - 1))
          state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        line_d = par_q ^ (PARITY == PAR_ODD);
        if (baud_last) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (baud_last && bit_cnt_q == BW'(STOP_BITS - 1)) begin
          done_d = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // bit_cnt counts data bits in DATA and stop bits in STOP.
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      serial_q <= line_d;
      active_q <= (state_q != ST_IDLE);
      done_q   <= done_d;
      if (pop) begin
        shift_q    <= fifo_rdata;
        par_q      <= ^fifo_rdata;
        baud_cnt_q <= '0;
        bit_cnt_q  <= '0;
      end else if (state_q != ST_IDLE) begin
        if (baud_last) begin
          baud_cnt_q <= '0;
          if (state_q == ST_DATA) begin
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= (bit_cnt_q == BW'(DATA_BITS - 1)) ? '0 : bit_cnt_q + 1'b1;
          end else if (state_q == ST_STOP) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end else begin
          baud_cnt_q <= baud_cnt_q + 1'b1;
        end
      end
    end
  end

  assign tx.o_tx_ready   = !fifo_full;
  assign tx.o_tx_serial  = serial_q;
  assign tx.o_tx_active  = active_q;
  assign tx.o_tx_done    = done_q;
  assign tx.o_fifo_count = fifo_count;
  assign tx.tx_state     = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1, 8E1, 8O1, CLKS_PER_BIT=4,
// depth 4) share one stimulus stream and are checked against a frame-schedule model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int NDUT  = 3;

  // ---------------- clock / reset ----------------
  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          valid = 1'b0;
  logic [DW-1:0] data  = '0;

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  uart_tx_fifo_if #(.DATA_BITS(DW), .FIFO_DEPTH(DEPTH)) if_n ();
  uart_tx_fifo_if #(.DATA_BITS(DW), .FIFO_DEPTH(DEPTH)) if_e ();
  uart_tx_fifo_if #(.DATA_BITS(DW), .FIFO_DEPTH(DEPTH)) if_o ();

  assign if_n.i_tx_valid = valid;
  assign if_n.i_tx_data  = data;
  assign if_e.i_tx_valid = valid;
  assign if_e.i_tx_data  = data;
  assign if_o.i_tx_valid = valid;
  assign if_o.i_tx_data  = data;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DW), .PARITY(PAR_NONE), .STOP_BITS(1),
                 .FIFO_DEPTH(DEPTH)) dut_n (.i_clk_sys(clk), .i_rst(rst), .tx(if_n));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DW), .PARITY(PAR_EVEN), .STOP_BITS(1),
                 .FIFO_DEPTH(DEPTH)) dut_e (.i_clk_sys(clk), .i_rst(rst), .tx(if_e));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DW), .PARITY(PAR_ODD), .STOP_BITS(1),
                 .FIFO_DEPTH(DEPTH)) dut_o (.i_clk_sys(clk), .i_rst(rst), .tx(if_o));

  logic          ser [NDUT];
  logic          act [NDUT];
  logic          dn  [NDUT];
  logic          rdy [NDUT];
  logic [CW-1:0] cnt [NDUT];

  assign ser[0] = if_n.o_tx_serial;  assign ser[1] = if_e.o_tx_serial;  assign ser[2] = if_o.o_tx_serial;
  assign act[0] = if_n.o_tx_active;  assign act[1] = if_e.o_tx_active;  assign act[2] = if_o.o_tx_active;
  assign dn[0]  = if_n.o_tx_done;    assign dn[1]  = if_e.o_tx_done;    assign dn[2]  = if_o.o_tx_done;
  assign rdy[0] = if_n.o_tx_ready;   assign rdy[1] = if_e.o_tx_ready;   assign rdy[2] = if_o.o_tx_ready;
  assign cnt[0] = if_n.o_fifo_count; assign cnt[1] = if_e.o_fifo_count; assign cnt[2] = if_o.o_fifo_count;

  // ---------------- scoreboard / model ----------------
  // Each frame is a bit list (start, data LSB first, optional parity, stop);
  // a word popped at edge P is on the line for the frame length after P+1.
  logic [DW-1:0] exp_q [NDUT][$];
  logic [DW-1:0] cur_word  [NDUT];
  int            pop_edge  [NDUT];
  int            frame_len [NDUT];
  int            par_mode  [NDUT];
  logic          e_ser [NDUT];
  logic          e_act [NDUT];
  logic          e_done[NDUT];
  logic          e_rdy [NDUT];
  int            e_cnt [NDUT];
  int            edge_no;
  int            n_cmp;
  int            n_fail;

  function automatic logic frame_bit(input logic [DW-1:0] w, input int mode, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return w[idx-1];
    if (mode != 0 && idx == DW + 1) return (^w) ^ (mode == 2);
    return 1'b1;
  endfunction

  task automatic model_edge();
    edge_no++;
    for (int i = 0; i < NDUT; i++) begin
      if (rst) begin
        exp_q[i].delete();
        pop_edge[i] = -1000;
        e_ser[i] = 1'b1; e_act[i] = 1'b0; e_done[i] = 1'b0; e_rdy[i] = 1'b1; e_cnt[i] = 0;
      end else begin
        int off;
        int sz;
        off       = edge_no - pop_edge[i] - 1;
        e_act[i]  = (off >= 0) && (off < frame_len[i]);
        e_ser[i]  = e_act[i] ? frame_bit(cur_word[i], par_mode[i], off / CPB) : 1'b1;
        e_done[i] = (off == frame_len[i] - 1);
        sz = exp_q[i].size();
        if (sz > 0 && edge_no >= pop_edge[i] + frame_len[i]) begin
          cur_word[i] = exp_q[i].pop_front();
          pop_edge[i] = edge_no;
        end
        if (valid && sz < DEPTH) exp_q[i].push_back(data);
        e_cnt[i] = exp_q[i].size();
        e_rdy[i] = (e_cnt[i] < DEPTH);
      end
    end
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at t=%0t", name, idx, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NDUT; i++) begin
      check("serial", i, 32'(ser[i]), 32'(e_ser[i]));
      check("active", i, 32'(act[i]), 32'(e_act[i]));
      check("done",   i, 32'(dn[i]),  32'(e_done[i]));
      check("ready",  i, 32'(rdy[i]), 32'(e_rdy[i]));
      check("count",  i, 32'(cnt[i]), 32'(e_cnt[i]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  function automatic bit models_idle();
    for (int i = 0; i < NDUT; i++)
      if (exp_q[i].size() != 0 || edge_no < pop_edge[i] + frame_len[i] + 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    int budget = 0;
    while (!models_idle() && budget < 800) begin
      step();
      budget++;
    end
    n_cmp++;
    if (budget >= 800) begin
      n_fail++;
      $display("FAIL drain_timeout: got busy expected idle within 800 cycles");
    end
    step();
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    valid = 1'b1;
    data  = w;
    step();
    valid = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  int            n_done [NDUT];
  int            done_at[NDUT];
  int            done_t [3];
  logic [9:0]    samp0;
  logic          par_s [NDUT];
  int            gap, maxc, budget;
  logic          seen_act, rdy_at_full;

  initial begin
    for (int i = 0; i < NDUT; i++) begin
      pop_edge[i] = -1000;
      cur_word[i] = '0;
      par_mode[i] = i;
      frame_len[i] = CPB * (1 + DW + ((i != 0) ? 1 : 0) + 1);
    end
    edge_no = 0;
    n_cmp   = 0;
    n_fail  = 0;

    repeat (3) step();
    for (int i = 0; i < NDUT; i++) begin
      check("reset_serial", i, 32'(ser[i]), 32'd1);
      check("reset_active", i, 32'(act[i]), 32'd0);
      check("reset_ready",  i, 32'(rdy[i]), 32'd1);
      check("reset_count",  i, 32'(cnt[i]), 32'd0);
    end
    rst = 1'b0;
    step();

    // single word 0xA5: line low two edges after the push
    push_word(8'hA5);
    check("t1_count_after_push", 0, 32'(cnt[0]), 32'd1);
    step();
    check("t1_line_idle_n1", 0, 32'(ser[0]), 32'd1);
    samp0 = '0;
    for (int i = 0; i < NDUT; i++) begin n_done[i] = 0; done_at[i] = -1; par_s[i] = 1'b0; end
    for (int k = 0; k < 48; k++) begin
      step();
      if (k == 0) check("t1_first_low", 0, 32'(ser[0]), 32'd0);
      if (k % 4 == 2 && k / 4 < 10) samp0[k/4] = ser[0];
      if (k == 38) begin par_s[1] = ser[1]; par_s[2] = ser[2]; end
      for (int i = 0; i < NDUT; i++)
        if (dn[i]) begin n_done[i]++; done_at[i] = k; end
    end
    check("t1_frame_bits", 0, 32'(samp0), 32'(10'b11_0100_1010));
    check("t1_done_count", 0, 32'(n_done[0]), 32'd1);
    check("t1_done_at", 0, 32'(done_at[0]), 32'd39);
    check("t1_active_after", 0, 32'(act[0]), 32'd0);
    check("t2_even_parity", 1, 32'(par_s[1]), 32'd0);
    check("t2_odd_parity", 2, 32'(par_s[2]), 32'd1);
    check("t2_done_at_even", 1, 32'(done_at[1]), 32'd43);
    check("t2_done_at_odd", 2, 32'(done_at[2]), 32'd43);
    drain();

    // three contiguous frames
    valid = 1'b1;
    data = 8'h01; step();
    data = 8'h02; step();
    data = 8'h03; step();
    valid = 1'b0;
    n_done[0] = 0; gap = 0; seen_act = 1'b0;
    for (int k = 0; k < 140; k++) begin
      step();
      if (seen_act && n_done[0] < 3 && !act[0]) gap++;
      if (act[0]) seen_act = 1'b1;
      if (dn[0]) begin
        if (n_done[0] < 3) done_t[n_done[0]] = edge_no;
        n_done[0]++;
      end
    end
    check("t3_done_count", 0, 32'(n_done[0]), 32'd3);
    check("t3_spacing_1", 0, 32'(done_t[1] - done_t[0]), 32'd40);
    check("t3_spacing_2", 0, 32'(done_t[2] - done_t[1]), 32'd40);
    check("t3_active_gaps", 0, 32'(gap), 32'd0);
    drain();

    // hold valid with the line busy until the FIFO fills
    maxc = 0; rdy_at_full = 1'b1;
    valid = 1'b1;
    for (int k = 0; k < 24; k++) begin
      data = 8'h30 + 8'(k);
      step();
      if (int'(cnt[0]) > maxc) begin
        maxc = int'(cnt[0]);
        if (maxc == DEPTH) rdy_at_full = rdy[0];
      end
    end
    valid = 1'b0;
    check("t4_max_count", 0, 32'(maxc), 32'd4);
    check("t4_ready_when_full", 0, 32'(rdy_at_full), 32'd0);
    check("t4_count_held", 0, 32'(cnt[0]), 32'd4);
    drain();

    // push lands on the edge where a frame ends and the next word pops
    valid = 1'b1;
    data = 8'h51; step();
    data = 8'h52; step();
    data = 8'h53; step();
    valid = 1'b0;
    check("t5_count_before", 0, 32'(cnt[0]), 32'd2);
    budget = 0;
    while (edge_no + 1 != pop_edge[0] + frame_len[0] && budget < 80) begin
      step();
      budget++;
    end
    n_cmp++;
    if (budget >= 80) begin
      n_fail++;
      $display("FAIL t5_wait_timeout: got no frame end expected one within 80 cycles");
    end
    push_word(8'h54);
    check("t5_count_same", 0, 32'(cnt[0]), 32'd2);
    check("t5_done_on_pop", 0, 32'(dn[0]), 32'd1);
    drain();

    // reset in the middle of a data bit
    valid = 1'b1;
    data = 8'hC3; step();
    data = 8'hC4; step();
    valid = 1'b0;
    repeat (10) step();
    #2 rst = 1'b1;
    #1;
    check("t6_serial_now", 0, 32'(ser[0]), 32'd1);
    check("t6_active_now", 0, 32'(act[0]), 32'd0);
    check("t6_count_now", 0, 32'(cnt[0]), 32'd0);
    n_done[0] = 0;
    repeat (2) begin step(); if (dn[0]) n_done[0]++; end
    rst = 1'b0;
    repeat (6) begin step(); if (dn[0]) n_done[0]++; end
    check("t6_no_done", 0, 32'(n_done[0]), 32'd0);
    check("t6_count_after", 0, 32'(cnt[0]), 32'd0);
    check("t6_line_high", 0, 32'(ser[0]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
